// File: rtl/toggle_decoder.sv
// Toggle-encoded event decoder: turns level changes on t_in into pulses, a
// saturating event count, and period measurements with a valid/ready handoff.
//
// state   | meaning
// IDLE    | no event seen since reset/clear
// ACTIVE  | events arriving; each event closes one period measurement
// STALLED | no event for TIMEOUT cycles; next event restarts timing
module toggle_decoder #(
  parameter int CNT_W   = 8,
  parameter int PER_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             t_in,
  input  logic             clr,
  output logic             level,
  output logic             pulse,
  output logic [CNT_W-1:0] cnt,
  output logic [PER_W-1:0] per_data,
  output logic             per_valid,
  input  logic             per_ready,
  output logic             ovf,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    STALLED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PER_W-1:0] PER_MAX = '1;
  localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);
  localparam logic [PER_W-1:0] PER_TO  = PER_W'(TIMEOUT);

  state_t           state, state_nxt;
  logic             t_q;
  logic             evt;
  logic             capture;
  logic [PER_W-1:0] per_cnt;

  assign level   = t_q;
  assign evt     = (t_in != t_q) && !rst && !clr;
  assign timeout = (state == STALLED);

  // t_q tracks t_in even through rst/clr so release never sees a stale edge
  always_ff @(posedge clk) begin
    t_q <= t_in;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (evt) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (evt)                    capture   = 1'b1;
        else if (per_cnt == PER_TO) state_nxt = STALLED;
      end
      STALLED: begin
        if (evt) state_nxt = ACTIVE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pulse   <= 1'b0;
      cnt     <= '0;
      per_cnt <= '0;
    end else begin
      pulse <= evt;
      if (evt && (cnt != CNT_MAX)) cnt <= cnt + CNT_ONE;
      if (evt)                     per_cnt <= PER_ONE;
      else if (per_cnt != PER_MAX) per_cnt <= per_cnt + PER_ONE;
    end
  end

  // per_data is kept across clr; only rst zeroes it
  always_ff @(posedge clk) begin
    if (rst) begin
      per_data  <= '0;
      per_valid <= 1'b0;
      ovf       <= 1'b0;
    end else if (clr) begin
      per_valid <= 1'b0;
      ovf       <= 1'b0;
    end else if (capture) begin
      if (!per_valid || per_ready) begin
        per_data  <= per_cnt;
        per_valid <= 1'b1;
      end else begin
        ovf <= 1'b1;
      end
    end else if (per_valid && per_ready) begin
      per_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_toggle_decoder.sv
// Bench for toggle_decoder: default-parameter instance plus a small one
// (CNT_W=3, TIMEOUT=20) sharing stimulus; per_data checked via a queue.
module tb_toggle_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clr, t_in, per_ready;

  logic        level, pulse, per_valid, ovf, timeout;
  logic [7:0]  cnt;
  logic [15:0] per_data;

  logic        level2, pulse2, per_valid2, ovf2, timeout2;
  logic [2:0]  cnt2;
  logic [15:0] per_data2;

  int checks   = 0;
  int errors   = 0;
  int mon_sel  = 0;
  int pulse_n  = 0;
  int pulse2_n = 0;
  logic [15:0] exp_q[$];

  toggle_decoder dut (
    .clk(clk), .rst(rst), .t_in(t_in), .clr(clr),
    .level(level), .pulse(pulse), .cnt(cnt),
    .per_data(per_data), .per_valid(per_valid), .per_ready(per_ready),
    .ovf(ovf), .timeout(timeout)
  );

  toggle_decoder #(.CNT_W(3), .PER_W(16), .TIMEOUT(20)) dut2 (
    .clk(clk), .rst(rst), .t_in(t_in), .clr(clr),
    .level(level2), .pulse(pulse2), .cnt(cnt2),
    .per_data(per_data2), .per_valid(per_valid2), .per_ready(per_ready),
    .ovf(ovf2), .timeout(timeout2)
  );

  // Scoreboard consumer: every handshake pops one expected measurement
  initial begin
    logic [15:0] e, d;
    logic v;
    forever begin
      @(negedge clk);
      if (pulse)  pulse_n++;
      if (pulse2) pulse2_n++;
      v = (mon_sel == 1) ? per_valid : (mon_sel == 2) ? per_valid2 : 1'b0;
      d = (mon_sel == 2) ? per_data2 : per_data;
      if (v && per_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra got per_data=%0d expected none queued", d);
        end else begin
          e = exp_q.pop_front();
          if (d !== e) begin
            errors++;
            $display("FAIL sb_per_data got %0d expected %0d", d, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic toggle();
    t_in = ~t_in;
    tick();
  endtask

  task automatic do_reset(input logic tval);
    rst  = 1'b1;
    clr  = 1'b0;
    t_in = tval;
    repeat (2) tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    mon_sel = 0;
    rst  = 1'b1;
    clr  = 1'b0;
    t_in = 1'b1;
    repeat (2) tick();
    checks++;
    if (cnt !== 8'd0 || pulse !== 1'b0 || per_valid !== 1'b0 || per_data !== 16'd0
        || ovf !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got cnt=%0d pulse=%b pv=%b pd=%0d ovf=%b to=%b expected all zero",
               cnt, pulse, per_valid, per_data, ovf, timeout);
    end
    rst = 1'b0;
    pulse_n = 0;
    repeat (10) tick();
    checks++;
    if (pulse_n != 0) begin
      errors++;
      $display("FAIL reset_no_pulse got %0d pulses expected 0", pulse_n);
    end
    checks++;
    if (cnt !== 8'd0 || level !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got cnt=%0d level=%b expected cnt=0 level=1", cnt, level);
    end
  endtask

  task automatic test_basic();
    do_reset(1'b0);
    per_ready = 1'b1;
    mon_sel   = 1;
    pulse_n   = 0;
    toggle();
    repeat (2) tick();
    exp_q.push_back(16'd3);
    toggle();
    repeat (6) tick();
    exp_q.push_back(16'd7);
    toggle();
    repeat (3) tick();
    checks++;
    if (cnt !== 8'd3 || pulse_n != 3) begin
      errors++;
      $display("FAIL basic_count got cnt=%0d pulses=%0d expected 3 and 3", cnt, pulse_n);
    end
    checks++;
    if (exp_q.size() != 0 || per_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain got queued=%0d pv=%b expected 0 and 0", exp_q.size(), per_valid);
    end
    mon_sel = 0;
  endtask

  task automatic test_overflow();
    do_reset(1'b0);
    per_ready = 1'b0;
    mon_sel   = 1;
    toggle();
    repeat (2) tick();
    exp_q.push_back(16'd3);
    toggle();
    repeat (3) tick();
    toggle();
    tick();
    checks++;
    if (per_data !== 16'd3 || per_valid !== 1'b1 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_hold got pd=%0d pv=%b ovf=%b expected 3 1 1", per_data, per_valid, ovf);
    end
    per_ready = 1'b1;
    tick();
    checks++;
    if (per_valid !== 1'b0 || ovf !== 1'b1 || per_data !== 16'd3) begin
      errors++;
      $display("FAIL ovf_accept got pv=%b ovf=%b pd=%0d expected 0 1 3", per_valid, ovf, per_data);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL ovf_drain got queued=%0d expected 0", exp_q.size());
    end
    mon_sel = 0;
  endtask

  task automatic test_capture_accept();
    do_reset(1'b0);
    per_ready = 1'b0;
    mon_sel   = 1;
    toggle();
    repeat (2) tick();
    exp_q.push_back(16'd3);
    toggle();
    repeat (3) tick();
    exp_q.push_back(16'd4);
    per_ready = 1'b1;
    toggle();
    checks++;
    if (per_valid !== 1'b1 || per_data !== 16'd4 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL cap_accept got pv=%b pd=%0d ovf=%b expected 1 4 0", per_valid, per_data, ovf);
    end
    tick();
    checks++;
    if (per_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL cap_accept_drain got pv=%b queued=%0d expected 0 0", per_valid, exp_q.size());
    end
    mon_sel = 0;
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0);
    per_ready = 1'b1;
    mon_sel   = 1;
    pulse_n   = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) exp_q.push_back(16'd1);
      toggle();
      checks++;
      if (pulse !== 1'b1) begin
        errors++;
        $display("FAIL b2b_pulse[%0d] got %b expected 1", i, pulse);
      end
    end
    tick();
    checks++;
    if (pulse !== 1'b0 || cnt !== 8'd4 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end got pulse=%b cnt=%0d ovf=%b expected 0 4 0", pulse, cnt, ovf);
    end
    tick();
    checks++;
    if (exp_q.size() != 0 || pulse_n != 4) begin
      errors++;
      $display("FAIL b2b_drain got queued=%0d pulses=%0d expected 0 4", exp_q.size(), pulse_n);
    end
    mon_sel = 0;
  endtask

  task automatic test_timeout();
    do_reset(1'b0);
    per_ready = 1'b1;
    mon_sel   = 2;
    toggle();
    repeat (19) tick();
    checks++;
    if (timeout2 !== 1'b0) begin
      errors++;
      $display("FAIL to_early got %b expected 0", timeout2);
    end
    tick();
    checks++;
    if (timeout2 !== 1'b1) begin
      errors++;
      $display("FAIL to_assert got %b expected 1", timeout2);
    end
    repeat (5) tick();
    checks++;
    if (timeout2 !== 1'b1) begin
      errors++;
      $display("FAIL to_hold got %b expected 1", timeout2);
    end
    toggle();
    checks++;
    if (timeout2 !== 1'b0 || per_valid2 !== 1'b0) begin
      errors++;
      $display("FAIL to_resume got to=%b pv=%b expected 0 0", timeout2, per_valid2);
    end
    repeat (3) tick();
    exp_q.push_back(16'd4);
    toggle();
    checks++;
    if (per_valid2 !== 1'b1) begin
      errors++;
      $display("FAIL to_measure got pv=%b expected 1", per_valid2);
    end
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL to_drain got queued=%0d expected 0", exp_q.size());
    end
    mon_sel = 0;
  endtask

  task automatic test_saturate_clr();
    int exp_c;
    do_reset(1'b0);
    per_ready = 1'b0;
    mon_sel   = 0;
    for (int i = 0; i < 10; i++) begin
      toggle();
      tick();
      exp_c = (i + 1 > 7) ? 7 : i + 1;
      checks++;
      if (cnt2 !== 3'(exp_c)) begin
        errors++;
        $display("FAIL sat_cnt[%0d] got %0d expected %0d", i, cnt2, exp_c);
      end
    end
    checks++;
    if (ovf2 !== 1'b1) begin
      errors++;
      $display("FAIL sat_ovf got %b expected 1", ovf2);
    end
    clr  = 1'b1;
    t_in = ~t_in;
    tick();
    clr = 1'b0;
    checks++;
    if (cnt2 !== 3'd0 || ovf2 !== 1'b0 || per_valid2 !== 1'b0 || pulse2 !== 1'b0
        || timeout2 !== 1'b0 || level2 !== t_in) begin
      errors++;
      $display("FAIL clr_state got cnt=%0d ovf=%b pv=%b pulse=%b to=%b level=%b expected 0 0 0 0 0 %b",
               cnt2, ovf2, per_valid2, pulse2, timeout2, level2, t_in);
    end
    tick();
    checks++;
    if (cnt2 !== 3'd0 || pulse2 !== 1'b0) begin
      errors++;
      $display("FAIL clr_no_event got cnt=%0d pulse=%b expected 0 0", cnt2, pulse2);
    end
    per_ready = 1'b1;
    toggle();
    checks++;
    if (cnt2 !== 3'd1 || pulse2 !== 1'b1 || per_valid2 !== 1'b0) begin
      errors++;
      $display("FAIL clr_idle got cnt=%0d pulse=%b pv=%b expected 1 1 0", cnt2, pulse2, per_valid2);
    end
  endtask

  task automatic test_mid_reset();
    do_reset(1'b0);
    per_ready = 1'b0;
    mon_sel   = 0;
    toggle();
    repeat (2) tick();
    toggle();
    checks++;
    if (per_valid !== 1'b1 || per_data !== 16'd3) begin
      errors++;
      $display("FAIL mid_pending got pv=%b pd=%0d expected 1 3", per_valid, per_data);
    end
    rst  = 1'b1;
    t_in = ~t_in;
    tick();
    checks++;
    if (per_valid !== 1'b0 || per_data !== 16'd0 || cnt !== 8'd0 || pulse !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got pv=%b pd=%0d cnt=%0d pulse=%b expected 0 0 0 0",
               per_valid, per_data, cnt, pulse);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (pulse !== 1'b0 || cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_release got pulse=%b cnt=%0d expected 0 0", pulse, cnt);
    end
    per_ready = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    clr       = 1'b0;
    t_in      = 1'b0;
    per_ready = 1'b1;
    test_reset();
    test_basic();
    test_overflow();
    test_capture_accept();
    test_back_to_back();
    test_timeout();
    test_saturate_clr();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/toggle_decoder.md
TOGGLE_DECODER -- requirements
Module: toggle_decoder

Interface
REQ-001 Parameter CNT_W, default 8, width of the event counter.
REQ-002 Parameter PER_W, default 16, width of the period measurement.
REQ-003 Parameter TIMEOUT, default 1000, number of idle cycles before a stall is declared; legal range 2..2^PER_W-1.
REQ-004 Port clk  input  1  single clock; all logic on the posedge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port t_in  input  1  toggle-encoded event line, synchronous to clk; each level change is one event.
REQ-007 Port clr  input  1  synchronous clear of the statistics and the state machine.
REQ-008 Port level  output  1  registered copy of t_in.
REQ-009 Port pulse  output  1  one-cycle strobe per decoded event.
REQ-010 Port cnt  output  CNT_W  saturating event count.
REQ-011 Port per_data  output  PER_W  cycles between the last two events.
REQ-012 Port per_valid  output  1  per_data holds an unread measurement.
REQ-013 Port per_ready  input  1  consumer accepts per_data.
REQ-014 Port ovf  output  1  sticky flag: a measurement was dropped.
REQ-015 Port timeout  output  1  high while the state is STALLED.

Function
REQ-016 The block SHALL register t_in into t_q (driven on level) every cycle, including during rst and clr.
REQ-017 An event SHALL occur at a clock edge when sampled t_in != t_q, with rst=0 and clr=0.
REQ-018 pulse SHALL be 1 for exactly the cycle after each event edge and 0 otherwise; back-to-back toggles give back-to-back pulses.
REQ-019 cnt SHALL increment by 1 per event and saturate at 2^CNT_W-1 with no wrap.
REQ-020 Internal per_cnt SHALL load 1 on an event; otherwise it SHALL increment, saturating at 2^PER_W-1.
REQ-021 The state machine SHALL have three states: IDLE (reset), ACTIVE, and STALLED.
REQ-022 IDLE->ACTIVE on the first event; no measurement is captured.
REQ-023 ACTIVE with an event: capture per_cnt as the measurement and stay ACTIVE.
REQ-024 ACTIVE with no event while per_cnt == TIMEOUT: go to STALLED.
REQ-025 STALLED->ACTIVE on an event; no measurement is captured (stall period discarded).
REQ-026 A capture with per_valid=0, or per_valid=1 with per_ready=1 in the same cycle, SHALL load per_data and set per_valid=1.
REQ-027 A capture with per_valid=1 and per_ready=0 SHALL keep per_data unchanged and set ovf=1.
REQ-028 per_valid=1 with per_ready=1 and no capture SHALL clear per_valid next cycle; per_data is held.
REQ-029 ovf SHALL stay set until rst or clr.
REQ-030 clr SHALL reset cnt, per_cnt, per_valid, ovf, pulse and state (IDLE) to their reset values.
REQ-031 An event coinciding with clr SHALL be discarded.
REQ-032 rst SHALL take priority over clr.

Reset
REQ-033 With rst=1 at an edge: pulse=0, cnt=0, per_data=0, per_valid=0, ovf=0, timeout=0, per_cnt=0, state=IDLE, and t_q=t_in, so no spurious event is seen after reset release.
REQ-034 rst asserted mid-operation SHALL abandon any pending measurement in the same edge.

Verification
REQ-035 Reset with t_in=1, release, hold t_in=1 for 10 cycles -> pulse never 1, cnt=0, level=1.
REQ-036 Toggle t_in at cycles 5, 8, 15, per_ready=1 -> three pulses, cnt=3, per_valid pulses carrying per_data=3 then 7.
REQ-037 per_ready=0, toggles at cycles 5, 8, 12 -> per_data=3 held, per_valid=1, ovf=1; then per_ready=1 -> per_valid=0 next cycle, ovf stays 1.
REQ-038 TIMEOUT=20, toggle once, idle 25 cycles -> timeout=1 from 20 cycles after the event; next toggle -> timeout=0, no measurement; following toggle 4 cycles later -> per_data=4.
REQ-039 CNT_W=3, 10 toggles -> cnt stops at 7; clr pulse -> cnt=0, state IDLE, ovf=0.
REQ-040 Capture and accept in the same cycle (per_valid=1, per_ready=1, event) -> new per_data loaded, per_valid stays 1, ovf=0.
